fetch_unit: RTL and testbench

Instruction-fetch stage: owns the fetch PC, issues one read at a time to a variable-latency instruction memory, and produces the `IR_F`/`PC4_F` pair consumed by the IF/ID pipeline register. It applies PC redirects with a fixed priority: exception/interrupt, then `eret`, then D-stage jump/branch. It discards stale memory responses after a redirect. It presents a NOP bubble (`IR_F = 0`) whenever no valid instruction is held.

---
 rtl/fetch_unit_pkg.sv | 6 +
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch FSM encodings and default PC constants shared across the core
package fetch_unit_pkg;
  typedef enum logic [1:0] {FS_REQ, FS_WAIT, FS_VALID, FS_DRAIN} fetch_state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with prioritised redirects and stale-response draining
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        jump_flush,
  input  logic [31:0] jump_target,
  input  logic        Int_M,
  input  logic        Iferet_M,
  input  logic [31:0] EPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR_F,
  output logic [31:0] PC4_F,
  output logic [31:0] PC_F,
  output logic        if_valid
);
  fetch_state_t state, state_nx;
  logic [31:0] pc, pc_nx, ibuf, ibuf_nx, redir_pc;
  logic redir;
  assign redir     = Int_M | Iferet_M | jump_flush;
  assign redir_pc  = (Int_M ? EXC_VEC : Iferet_M ? EPC : jump_target) & 32'hFFFF_FFFC;
  assign imem_req  = (state == FS_REQ) && !reset;
  assign imem_addr = pc;
  assign if_valid  = (state == FS_VALID);
  assign IR_F      = if_valid ? ibuf : 32'h0;
  assign PC4_F     = pc + 32'd4;
  assign PC_F      = pc;
  always_comb begin
    state_nx = state;
    pc_nx    = redir ? redir_pc : pc;
    ibuf_nx  = ibuf;
    case (state)
      FS_REQ:   state_nx = redir ? FS_DRAIN : FS_WAIT;
      FS_WAIT: begin
        if (imem_rvalid) begin
          state_nx = redir ? FS_REQ : FS_VALID;
          ibuf_nx  = redir ? ibuf : imem_rdata;
        end else if (redir) begin
          state_nx = FS_DRAIN;
        end
      end
      FS_DRAIN: state_nx = imem_rvalid ? FS_REQ : FS_DRAIN;
      FS_VALID: begin
        if (redir) begin
          state_nx = FS_REQ;
        end else if (en) begin
          state_nx = FS_REQ;
          pc_nx    = pc + 32'd4;
        end
      end
      default:  state_nx = FS_REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FS_REQ;
      pc    <= RESET_PC;
      ibuf  <= 32'h0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ibuf  <= ibuf_nx;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a variable-latency memory model
module tb_fetch_unit;
  logic clk = 0, reset = 1, en = 0, jump_flush = 0, Int_M = 0, Iferet_M = 0;
  logic [31:0] jump_target = 0, EPC = 0;
  logic imem_req, imem_rvalid, if_valid;
  logic [31:0] imem_addr, imem_rdata, IR_F, PC4_F, PC_F;
  int n_checks = 0, n_errors = 0;
  int lat = 1, cnt = 0;
  logic pend = 0;
  logic [31:0] paddr = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .en(en), .jump_flush(jump_flush), .jump_target(jump_target),
    .Int_M(Int_M), .Iferet_M(Iferet_M), .EPC(EPC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .IR_F(IR_F), .PC4_F(PC4_F),
    .PC_F(PC_F), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  // memory: word at 0x3000 is 0x24080001, every other address returns ~addr
  assign imem_rvalid = pend && cnt == 0;
  assign imem_rdata  = imem_rvalid ? (paddr == 32'h3000 ? 32'h2408_0001 : ~paddr) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (reset) pend <= 0;
    else if (imem_req) begin
      pend <= 1; paddr <= imem_addr; cnt <= lat - 1;
    end else if (pend) begin
      if (cnt == 0) pend <= 0;
      else cnt <= cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    int k = 0;
    while (!imem_req && k < 30) begin
      check({tag, "_nobubble"}, {31'b0, if_valid}, 32'd0);
      tick; k++;
    end
    check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    tick; tick;
    check("rst_req", {31'b0, imem_req}, 0);
    check("rst_valid", {31'b0, if_valid}, 0);
    check("rst_ir", IR_F, 0);
    check("rst_pc", PC_F, 32'h3000);
    check("rst_pc4", PC4_F, 32'h3004);
    reset = 0; #1;
    check("c1_req", {31'b0, imem_req}, 1);
    check("c1_addr", imem_addr, 32'h3000);
    tick;
    check("c2_noreq", {31'b0, imem_req}, 0);
    tick;
    check("c3_valid", {31'b0, if_valid}, 1);
    check("c3_ir", IR_F, 32'h2408_0001);
    check("c3_pc4", PC4_F, 32'h3004);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("hold_ir", IR_F, 32'h2408_0001);
      check("hold_pc", PC_F, 32'h3000);
      check("hold_req", {31'b0, imem_req}, 0);
    end
    en = 1; tick; en = 0;
    check("next_addr", imem_addr, 32'h3004);
    check("next_req", {31'b0, imem_req}, 1);
    tick; tick;
    check("ir2", IR_F, 32'hFFFF_CFFB);
    lat = 5; en = 1; tick; en = 0;
    check("req3_addr", imem_addr, 32'h3008);
    tick;
    jump_flush = 1; jump_target = 32'h3100; tick; jump_flush = 0;
    check("jmp_pc", PC_F, 32'h3100);
    check("jmp_novalid", {31'b0, if_valid}, 0);
    wait_req("jmp", 32'h3100);
    lat = 1; tick; tick;
    check("jmp_ir", IR_F, 32'hFFFF_CEFF);
    Int_M = 1; Iferet_M = 1; EPC = 32'h3040; jump_flush = 1; jump_target = 32'h3200;
    tick;
    Int_M = 0; Iferet_M = 0; jump_flush = 0;
    check("prio_req", {31'b0, imem_req}, 1);
    check("prio_addr", imem_addr, 32'h4180);
    tick; tick;
    check("prio_ir", IR_F, 32'hFFFF_BE7F);
    jump_flush = 1; jump_target = 32'hFFFF_FFFF; tick; jump_flush = 0;
    check("wrap_pc", PC_F, 32'hFFFF_FFFC);
    check("wrap_pc4", PC4_F, 32'h0);
    tick; tick;
    check("wrap_valid", {31'b0, if_valid}, 1);
    en = 1; tick; en = 0;
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", {31'b0, imem_req}, 1);
    lat = 5; jump_flush = 1; jump_target = 32'h3300; tick; jump_flush = 0;
    check("drain_pc", PC_F, 32'h3300);
    check("drain_req", {31'b0, imem_req}, 0);
    reset = 1; tick;
    check("mrst_pc", PC_F, 32'h3000);
    check("mrst_ir", IR_F, 0);
    check("mrst_req", {31'b0, imem_req}, 0);
    tick;
    check("mrst_req2", {31'b0, imem_req}, 0);
    reset = 0; lat = 1; #1;
    check("mrst_rel_req", {31'b0, imem_req}, 1);
    check("mrst_rel_addr", imem_addr, 32'h3000);
    tick; tick;
    check("mrst_ir2", IR_F, 32'h2408_0001);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
